// File: rtl/multi_input_adder_with_rounding_pkg.sv
// Shared width/shift/saturation helpers for the multi-input rounding adder.
package multi_input_adder_pkg;

  // Exact-sum width: one growth bit per tree level.
  function automatic int sum_width(int num_input, int width_in);
    return (num_input > 1) ? width_in + $clog2(num_input) : width_in;
  endfunction

  // Tree depth; a single operand needs no adders.
  function automatic int tree_levels(int num_input);
    return (num_input > 1) ? $clog2(num_input) : 0;
  endfunction

  // Binary-point realignment: positive drops LSBs (rounded), negative pads LSBs.
  function automatic int frac_shift(int width_in, int width_out);
    return width_in - width_out;
  endfunction

  // Clamp into the representable result range. The 64-bit container is wider
  // than any intermediate the top module builds, so the compare is exact.
  function automatic longint saturate(longint value, int width_out, bit is_signed);
    longint hi, lo;
    if (is_signed) begin
      hi = (longint'(1) <<< (width_out - 1)) - 1;
      lo = -(longint'(1) <<< (width_out - 1));
    end else begin
      hi = (longint'(1) <<< width_out) - 1;
      lo = 0;
    end
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/multi_input_adder_with_rounding_adder_tree.sv
// Combinational balanced adder tree; leaves padded to a power of two with 0.
module adder_tree
  import multi_input_adder_pkg::*;
#(
  parameter int NUM_INPUT = 4,
  parameter int WIDTH_IN  = 8,
  parameter int SUM_W     = sum_width(NUM_INPUT, WIDTH_IN)
) (
  input  logic [WIDTH_IN-1:0] operands [NUM_INPUT],
  input  logic                is_signed,
  output logic [SUM_W-1:0]    sum
);

  localparam int LEVELS = tree_levels(NUM_INPUT);
  localparam int LEAVES = 1 << LEVELS;

  // node[l][i]: partial sums at level l; level 0 holds the extended operands
  logic [SUM_W-1:0] node [LEVELS+1][LEAVES];

  genvar l, i;

  // Leaf extension; missing leaves are zero so they never inject X
  for (i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < NUM_INPUT) begin : g_op
      if (SUM_W > WIDTH_IN) begin : g_ext
        assign node[0][i] = {{(SUM_W-WIDTH_IN){is_signed & operands[i][WIDTH_IN-1]}}, operands[i]};
      end else begin : g_noext
        assign node[0][i] = operands[i];
      end
    end else begin : g_pad
      assign node[0][i] = '0;
    end
  end

  // Pairwise reduction; slots above the live count at each level tie to 0
  for (l = 0; l < LEVELS; l++) begin : g_lvl
    for (i = 0; i < LEAVES; i++) begin : g_node
      if (i < (LEAVES >> (l + 1))) begin : g_add
        assign node[l+1][i] = node[l][2*i] + node[l][2*i+1];
      end else begin : g_zero
        assign node[l+1][i] = '0;
      end
    end
  end

  assign sum = node[LEVELS][0];

endmodule

// File: rtl/multi_input_adder_with_rounding.sv
// N-operand adder: exact tree sum, optional fraction realign/round, saturate,
// then one ena-gated register with async active-low reset.
module multi_input_adder_with_rounding
  import multi_input_adder_pkg::*;
#(
  parameter int NUM_INPUT   = 4,
  parameter int WIDTH_IN    = 8,
  parameter int WIDTH_OUT   = 8,
  parameter int IS_SIGNED   = 1,
  parameter int IS_FRACTION = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [WIDTH_IN-1:0]  din [NUM_INPUT],
  output logic [WIDTH_OUT-1:0] dout
);

  localparam int SUM_W = sum_width(NUM_INPUT, WIDTH_IN);
  localparam int SH    = frac_shift(WIDTH_IN, WIDTH_OUT);

  logic [SUM_W-1:0]     sum;
  longint               sum64;
  longint               value;
  logic [WIDTH_OUT-1:0] sat;

  adder_tree #(
    .NUM_INPUT (NUM_INPUT),
    .WIDTH_IN  (WIDTH_IN),
    .SUM_W     (SUM_W)
  ) u_tree (
    .operands  (din),
    .is_signed (IS_SIGNED != 0),
    .sum       (sum)
  );

  // Widen the exact sum into a 64-bit signed container for rounding/clamping
  assign sum64 = (IS_SIGNED != 0) ? longint'($signed(sum)) : longint'(sum);

  // Rounding add happens in the wide container, so it can never wrap
  if (IS_FRACTION != 0 && SH > 0) begin : g_round
    assign value = (sum64 + (longint'(1) <<< (SH - 1))) >>> SH;
  end else if (IS_FRACTION != 0) begin : g_pad
    assign value = sum64 <<< (-SH);
  end else begin : g_int
    assign value = sum64;
  end

  assign sat = WIDTH_OUT'(saturate(value, WIDTH_OUT, IS_SIGNED != 0));

  // Output register: reset dominates, ena=0 holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dout <= '0;
    else if (ena) dout <= sat;
  end

endmodule

// File: tb/tb_multi_input_adder_with_rounding.sv
// Scoreboard bench: five DUT configurations share clk/rst_n/ena and operands.
module tb_multi_input_adder_with_rounding;

  typedef logic [4:0][7:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  vec_t       ops = '0;
  logic [7:0] din4 [4];
  logic [7:0] din1 [1];
  logic [7:0] din5 [5];
  logic [7:0] dout0, dout2, dout3, dout4;
  logic [3:0] dout1;

  int   n_chk = 0;
  int   n_pass = 0;
  vec_t sbq [$];
  vec_t last = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) din4[i] = ops[i];
    din1[0] = ops[0];
    for (int i = 0; i < 5; i++) din5[i] = ops[i];
  end

  // default: signed integer 4x8 -> 8
  multi_input_adder_with_rounding #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8), .IS_SIGNED(1), .IS_FRACTION(0))
    u_d0 (.clk(clk), .rst_n(rst_n), .ena(ena), .din(din4), .dout(dout0));
  // signed fraction 8 -> 4 (SH=4)
  multi_input_adder_with_rounding #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(4), .IS_SIGNED(1), .IS_FRACTION(1))
    u_d1 (.clk(clk), .rst_n(rst_n), .ena(ena), .din(din4), .dout(dout1));
  // unsigned integer
  multi_input_adder_with_rounding #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8), .IS_SIGNED(0), .IS_FRACTION(0))
    u_d2 (.clk(clk), .rst_n(rst_n), .ena(ena), .din(din4), .dout(dout2));
  // single operand
  multi_input_adder_with_rounding #(.NUM_INPUT(1), .WIDTH_IN(8), .WIDTH_OUT(8), .IS_SIGNED(1), .IS_FRACTION(0))
    u_d3 (.clk(clk), .rst_n(rst_n), .ena(ena), .din(din1), .dout(dout3));
  // non-power-of-two operand count
  multi_input_adder_with_rounding #(.NUM_INPUT(5), .WIDTH_IN(8), .WIDTH_OUT(8), .IS_SIGNED(1), .IS_FRACTION(0))
    u_d4 (.clk(clk), .rst_n(rst_n), .ena(ena), .din(din5), .dout(dout4));

  // Integer golden model: exact sum, floor-rounded half-up shift, clamp
  function automatic longint model(int n, int wout, bit sgn, bit frac, vec_t v);
    longint s, d, t, hi, lo;
    int sh;
    s = 0;
    for (int i = 0; i < n; i++) s += sgn ? longint'($signed(v[i])) : longint'(v[i]);
    if (frac) begin
      sh = 8 - wout;
      if (sh > 0) begin
        d = longint'(1) << sh;
        t = s + d / 2;
        s = (t >= 0) ? t / d : -((-t + d - 1) / d);
      end else begin
        s = s * (longint'(1) << (-sh));
      end
    end
    hi = sgn ? (longint'(1) << (wout - 1)) - 1 : (longint'(1) << wout) - 1;
    lo = sgn ? -(longint'(1) << (wout - 1)) : 0;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic vec_t mk(int a, int b, int c, int d, int e);
    vec_t v;
    v[0] = 8'(a); v[1] = 8'(b); v[2] = 8'(c); v[3] = 8'(d); v[4] = 8'(e);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input vec_t e);
    chk("d0_int", dout0, e[0]);
    chk("d1_frac", {4'b0, dout1}, {4'b0, e[1][3:0]});
    chk("d2_uns", dout2, e[2]);
    chk("d3_n1", dout3, e[3]);
    chk("d4_n5", dout4, e[4]);
  endtask

  // Drive one cycle; expected values queued at drive time, popped after the edge
  task automatic apply(input vec_t v, input logic en);
    vec_t e;
    ops = v;
    ena = en;
    if (en) begin
      e[0] = 8'(model(4, 8, 1'b1, 1'b0, v));
      e[1] = 8'(model(4, 4, 1'b1, 1'b1, v));
      e[2] = 8'(model(4, 8, 1'b0, 1'b0, v));
      e[3] = 8'(model(1, 8, 1'b1, 1'b0, v));
      e[4] = 8'(model(5, 8, 1'b1, 1'b0, v));
    end else begin
      e = last;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_all(e);
    last = e;
  endtask

  initial begin
    // Reset held across enabled edges with live data: output stays 0
    ena = 1'b1;
    ops = mk(10, 20, 30, 40, 5);
    repeat (3) @(posedge clk);
    #1;
    check_all('0);
    #3 rst_n = 1'b1;
    last = '0;
    @(posedge clk);
    #1;
    chk("first_load", dout0, 8'd100);
    last = '0;

    apply(mk(10, 20, 30, 40, 0), 1'b1);
    chk("sum100", dout0, 8'd100);
    apply(mk(-50, 30, -20, 10, 0), 1'b1);
    chk("sum_neg30", dout0, 8'(-30));
    apply(mk(127, 127, 127, 127, 0), 1'b1);
    chk("sat_hi", dout0, 8'd127);
    apply(mk(-128, -128, -128, -128, -128), 1'b1);
    chk("sat_lo", dout0, 8'h80);
    apply(mk(8, 0, 0, 0, 0), 1'b1);
    chk("frac_half_up", {4'b0, dout1}, 8'd1);
    apply(mk(7, 0, 0, 0, 0), 1'b1);
    chk("frac_below_half", {4'b0, dout1}, 8'd0);
    apply(mk(-8, 0, 0, 0, 0), 1'b1);
    chk("frac_neg_half", {4'b0, dout1}, 8'd0);
    apply(mk(25, 50, 75, 100, 0), 1'b1);
    chk("frac_sat", {4'b0, dout1}, 8'd7);
    apply(mk(200, 200, 0, 0, 0), 1'b1);
    chk("uns_sat", dout2, 8'd255);
    apply(mk(1, 2, 3, 4, 5), 1'b1);
    chk("uns_10", dout2, 8'd10);
    chk("n5_15", dout4, 8'd15);
    chk("n1_pass", dout3, 8'd1);

    // Hold: new operands with ena low for three edges
    for (int k = 0; k < 3; k++) begin
      apply(mk(99 + k, 1, 1, 1, 1), 1'b0);
      chk("hold", dout4, 8'd15);
    end

    // Async reset pulse mid-cycle, ena low so the following edge must not load
    ena = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all('0);
    #2 rst_n = 1'b1;
    last = '0;
    @(posedge clk);
    #1 check_all('0);
    apply(mk(10, 20, 30, 40, 0), 1'b1);
    chk("post_rst_load", dout0, 8'd100);

    // Random regression with occasional ena=0
    for (int k = 0; k < 10000; k++) begin
      vec_t v;
      for (int j = 0; j < 5; j++) v[j] = 8'($urandom);
      apply(v, $urandom_range(0, 7) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
